// File: rtl/alu_issue_sched_if.sv
// -----------------------------------------------------------------------------
// types package + alu_issue_sched_if
//
// Purpose:
//   Holds the ALU operation encoding shared by the scheduler, its ALU and the
//   reservation stations. Also defines the request/CDB bundle between the
//   reservation stations and the issue scheduler.
//
// Interface signals (NUM_REQ ports, TAG_W tag bits):
//   req_valid [NUM_REQ]        port has an op with operands ready
//   req_op    [NUM_REQ]        ALU operation (types::alu_op_t)
//   req_a     [NUM_REQ] x 32   operand A
//   req_b     [NUM_REQ] x 32   operand B
//   req_tag   [NUM_REQ] x TAG_W destination tag
//   req_grant [NUM_REQ]        one-hot grant; op consumed at this clock edge
//   cdb_valid                  result register holds a valid result
//   cdb_ready                  CDB accepts the result this cycle
//   cdb_tag   TAG_W            tag of the held result
//   cdb_data  32               ALU result
//
// Modports:
//   master : requester / CDB side (drives requests and cdb_ready)
//   slave  : scheduler side
// -----------------------------------------------------------------------------
package types;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;
endpackage

interface alu_issue_sched_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 6
);
    logic [NUM_REQ-1:0]                 req_valid;
    types::alu_op_t [NUM_REQ-1:0]       req_op;
    logic [NUM_REQ-1:0][31:0]           req_a;
    logic [NUM_REQ-1:0][31:0]           req_b;
    logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag;
    logic [NUM_REQ-1:0]                 req_grant;
    logic                               cdb_valid;
    logic                               cdb_ready;
    logic [TAG_W-1:0]                   cdb_tag;
    logic [31:0]                        cdb_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, cdb_ready,
        input  req_grant, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, cdb_ready,
        output req_grant, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/alu_issue_sched.sv
// -----------------------------------------------------------------------------
// alu_issue_sched
//
// Purpose:
//   Round-robin issue scheduler for the shared integer ALU. Picks one ready
//   reservation-station port per cycle, runs its op through the ALU and
//   registers the result with its tag for the common data bus, honouring
//   valid/ready backpressure and pipeline flush.
//
// Ports:
//   clk        core clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline flush; drops the held result, blocks grant
//   bus        alu_issue_sched_if.slave (requests, one-hot grant, CDB output)
//   perf_issue_cnt / perf_stall_cnt (32 each)
//              only when ALU_ISSUE_SCHED_PERF_EN is defined: grants issued and
//              cycles with a pending request blocked by a full, stalled CDB
//
// Configuration macro: ALU_ISSUE_SCHED_PERF_EN
// -----------------------------------------------------------------------------

// Combinational integer ALU. Undefined op codes produce zero.
module alu (
    input  types::alu_op_t op,
    input  logic [31:0]    a,
    input  logic [31:0]    b,
    output logic [31:0]    y
);
    always_comb begin
        y = '0;
        case (op)
            types::ALU_ADD:  y = a + b;
            types::ALU_SUB:  y = a - b;
            types::ALU_AND:  y = a & b;
            types::ALU_OR:   y = a | b;
            types::ALU_XOR:  y = a ^ b;
            types::ALU_SLL:  y = a << b[4:0];
            types::ALU_SRL:  y = a >> b[4:0];
            types::ALU_SRA:  y = $unsigned($signed(a) >>> b[4:0]);
            types::ALU_SLT:  y = {31'b0, $signed(a) < $signed(b)};
            types::ALU_SLTU: y = {31'b0, a < b};
            default:         y = '0;
        endcase
    end
endmodule

module alu_issue_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_sched_if.slave   bus
`ifdef ALU_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_issue_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TAG_W-1:0]   res_tag;
    logic [31:0]        res_data;

    logic               can_issue;
    logic               found;
    logic [IDX_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    int unsigned        idx;

    types::alu_op_t     alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [31:0]        alu_y;

    // A result slot is available when empty or being drained this cycle.
    assign can_issue = (state == EMPTY) || bus.cdb_ready;

    // Scan from rr_ptr upward with wrap; first valid port wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        grant = '0;
        if (rst_n && can_issue && !flush) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                idx = 32'(rr_ptr) + i;
                if (idx >= NUM_REQ)
                    idx = idx - NUM_REQ;
                if (!found && bus.req_valid[idx[IDX_W-1:0]]) begin
                    found = 1'b1;
                    sel   = idx[IDX_W-1:0];
                end
            end
        end
        grant[sel] = found;
    end

    assign alu_op = bus.req_op[sel];
    assign alu_a  = bus.req_a[sel];
    assign alu_b  = bus.req_b[sel];

    alu u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Flush wins over both a new grant (already blocked above) and a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            res_tag  <= '0;
            res_data <= '0;
            rr_ptr   <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (found) begin
            state    <= FULL;
            res_data <= alu_y;
            res_tag  <= bus.req_tag[sel];
            rr_ptr   <= (32'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
        end else if (bus.cdb_ready) begin
            state <= EMPTY;
        end
    end

    assign bus.req_grant = grant;
    assign bus.cdb_valid = (state == FULL);
    assign bus.cdb_tag   = res_tag;
    assign bus.cdb_data  = res_data;

`ifdef ALU_ISSUE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (found)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((|bus.req_valid) && !can_issue && !flush)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_sched
//
// Purpose:
//   Self-checking bench for alu_issue_sched: directed scenarios followed by a
//   randomized run, all checked against a cycle-level reference model kept
//   here. Honours ALU_ISSUE_SCHED_PERF_EN for the performance counters.
// -----------------------------------------------------------------------------
module tb_alu_issue_sched;
    localparam int unsigned N  = 4;
    localparam int unsigned TW = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    alu_issue_sched_if #(.NUM_REQ(N), .TAG_W(TW)) bus ();

`ifdef ALU_ISSUE_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    alu_issue_sched #(.NUM_REQ(N), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
`ifdef ALU_ISSUE_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Stimulus state (what the requesters present)
    bit              v   [N];
    logic [3:0]      opc [N];
    logic [31:0]     ra  [N];
    logic [31:0]     rb  [N];
    logic [TW-1:0]   rt  [N];
    bit              rdy;

    // Reference model state
    int              m_rr;
    bit              m_valid;
    logic [TW-1:0]   m_tag;
    logic [31:0]     m_data;
    logic [31:0]     m_issue;
    logic [31:0]     m_stall;
    int              last_g;
    logic [N-1:0]    obs_grant;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (code)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_pick();
        if (flush || (m_valid && !rdy))
            return -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (v[p])
                return p;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rr    = 0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        m_issue = '0;
        m_stall = '0;
    endtask

    task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [TW-1:0] t);
        v[p]   = 1'b1;
        opc[p] = op;
        ra[p]  = a;
        rb[p]  = b;
        rt[p]  = t;
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            bus.req_valid[p] = v[p];
            bus.req_op[p]    = types::alu_op_t'(opc[p]);
            bus.req_a[p]     = ra[p];
            bus.req_b[p]     = rb[p];
            bus.req_tag[p]   = rt[p];
        end
        bus.cdb_ready = rdy;
    endtask

    // One clock cycle: drive, check at the falling edge, advance model, pass the edge.
    task automatic tick();
        int           g;
        bit           any_v;
        logic [N-1:0] eg;
        drive();
        @(negedge clk);
        g  = model_pick();
        eg = '0;
        if (g >= 0)
            eg[g] = 1'b1;
        obs_grant = bus.req_grant;
        check("grant", 64'(bus.req_grant), 64'(eg));
        check("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
        if (m_valid) begin
            check("cdb_tag", 64'(bus.cdb_tag), 64'(m_tag));
            check("cdb_data", 64'(bus.cdb_data), 64'(m_data));
        end
`ifdef ALU_ISSUE_SCHED_PERF_EN
        check("perf_issue", 64'(perf_issue_cnt), 64'(m_issue));
        check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
        any_v = 1'b0;
        for (int p = 0; p < N; p++)
            any_v |= v[p];
        if (any_v && m_valid && !rdy && !flush)
            m_stall = m_stall + 32'd1;
        if (flush) begin
            m_valid = 1'b0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = ref_alu(opc[g], ra[g], rb[g]);
            m_tag   = rt[g];
            m_rr    = (g + 1) % N;
            m_issue = m_issue + 32'd1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int p = 0; p < N; p++) begin
            v[p] = 1'b0; opc[p] = '0; ra[p] = '0; rb[p] = '0; rt[p] = '0;
        end
        rdy = 1'b0;
        model_reset();
        last_g = -1;
        drive();

        // Reset state while held
        #12;
        check("rst_valid", 64'(bus.cdb_valid), 64'd0);
        check("rst_tag", 64'(bus.cdb_tag), 64'd0);
        check("rst_data", 64'(bus.cdb_data), 64'd0);
        check("rst_grant", 64'(bus.req_grant), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset
        repeat (10) tick();

        // Single port 2 ADD, then SRA
        rdy = 1'b1;
        set_req(2, 4'(types::ALU_ADD), 32'd5, 32'd7, 6'd3);
        tick();
        v[2] = 1'b0;
        check("add_grant", 64'(obs_grant), 64'h4);
        check("add_valid", 64'(bus.cdb_valid), 64'd1);
        check("add_data", 64'(bus.cdb_data), 64'd12);
        check("add_tag", 64'(bus.cdb_tag), 64'd3);
        set_req(2, 4'(types::ALU_SRA), 32'h8000_0000, 32'd4, 6'd9);
        tick();
        v[2] = 1'b0;
        check("sra_grant", 64'(obs_grant), 64'h4);
        check("sra_data", 64'(bus.cdb_data), 64'hF800_0000);
        check("sra_tag", 64'(bus.cdb_tag), 64'd9);

        // Move pointer past port 3 so the sweep starts at 0
        set_req(3, 4'(types::ALU_ADD), 32'd1, 32'd1, 6'd1);
        tick();
        v[3] = 1'b0;

        // All ports requesting: order 0,1,2,3,0 with back-to-back results
        for (int p = 0; p < N; p++)
            set_req(p, 4'(types::ALU_ADD), 32'(p), 32'd100, 6'(8 + p));
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_order", 64'(obs_grant), 64'(1 << (k % 4)));
            check("rr_valid", 64'(bus.cdb_valid), 64'd1);
            check("rr_tag", 64'(bus.cdb_tag), 64'(8 + (k % 4)));
        end
        for (int p = 0; p < N; p++)
            v[p] = 1'b0;

        // Backpressure: result of port 0 (100, tag 8) must hold
        rdy = 1'b0;
        set_req(1, 4'(types::ALU_SUB), 32'd50, 32'd8, 6'd21);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_grant", 64'(obs_grant), 64'd0);
            check("bp_data", 64'(bus.cdb_data), 64'd100);
            check("bp_tag", 64'(bus.cdb_tag), 64'd8);
        end
        rdy = 1'b1;
        tick();
        v[1] = 1'b0;
        check("bp_release_grant", 64'(obs_grant), 64'h2);
        check("bp_release_data", 64'(bus.cdb_data), 64'd42);
        check("bp_release_tag", 64'(bus.cdb_tag), 64'd21);

        // Bring pointer to 0, then flush with a held result
        set_req(3, 4'(types::ALU_XOR), 32'hFF00_FF00, 32'h0F0F_0F0F, 6'd30);
        tick();
        v[3] = 1'b0;
        check("xor_data", 64'(bus.cdb_data), 64'hF00F_F00F);
        rdy   = 1'b0;
        flush = 1'b1;
        set_req(0, 4'(types::ALU_OR), 32'd1, 32'd2, 6'd5);
        set_req(1, 4'(types::ALU_AND), 32'hF0, 32'h3C, 6'd6);
        tick();
        check("flush_grant", 64'(obs_grant), 64'd0);
        check("flush_valid", 64'(bus.cdb_valid), 64'd0);
        flush = 1'b0;
        rdy   = 1'b1;
        tick();
        v[0] = 1'b0;
        check("post_flush_grant", 64'(obs_grant), 64'h1);
        check("post_flush_data", 64'(bus.cdb_data), 64'd3);

        // Asynchronous reset mid-stream with a valid result held
        check("pre_rst_valid", 64'(bus.cdb_valid), 64'd1);
`ifdef ALU_ISSUE_SCHED_PERF_EN
        check("pre_rst_issue", 64'(perf_issue_cnt), 64'(m_issue));
        check("pre_rst_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.cdb_valid), 64'd0);
        check("async_rst_grant", 64'(bus.req_grant), 64'd0);
        check("async_rst_data", 64'(bus.cdb_data), 64'd0);
`ifdef ALU_ISSUE_SCHED_PERF_EN
        check("async_rst_issue", 64'(perf_issue_cnt), 64'd0);
        check("async_rst_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        model_reset();
        for (int p = 0; p < N; p++)
            v[p] = 1'b0;
        rst_n = 1'b1;

        // Randomized traffic, including undefined op codes and flushes
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (last_g == p)
                    v[p] = 1'b0;
                if (!v[p] && ($urandom_range(0, 99) < 55))
                    set_req(p, 4'($urandom_range(0, 15)), $urandom(),
                            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom(),
                            6'($urandom_range(0, 63)));
            end
            rdy   = ($urandom_range(0, 99) < 70);
            flush = ($urandom_range(0, 99) < 5);
            tick();
        end
        flush = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
